// File: rtl/ptw_mem_responder.sv
// ptw_mem_responder: memory-side responder for the page-table walker read port.
// Accepts one PTE read at a time. It issues the read on the core data bus when the
// arbiter grants the bus, and returns the PTE as a one-cycle pulse. A bus error, a
// misaligned address, a timeout or (with PTW_PMA_CHECK_EN) an out-of-range address
// returns an all-zero PTE (V=0). The walker then takes a page fault instead of hanging.
// Optional feature macro: PTW_PMA_CHECK_EN (PTE address range check [PT_BASE,PT_LIMIT]).
// Ports:
//   clk, reset_n                              clock, async active-low reset
//   ptw_req_valid/addr/ready                  walker request handshake
//   ptw_resp_valid/data                       one-cycle PTE response
//   ptw_abort                                 satp write / sfence, drops the in-flight walk
//   bus_grant                                 arbiter grant for this cycle
//   bus_req_valid/addr/ready                  data-bus read request
//   bus_rsp_valid/data/err                    data-bus read response
//   fault_count                               saturating count of zero-PTE substitutions
module ptw_mem_responder #(
  parameter int XLEN = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter logic [XLEN-1:0] PT_BASE = '0,
  parameter logic [XLEN-1:0] PT_LIMIT = '1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ptw_req_valid,
  input  logic [XLEN-1:0] ptw_req_addr,
  output logic            ptw_req_ready,
  output logic [XLEN-1:0] ptw_resp_data,
  output logic            ptw_resp_valid,
  input  logic            ptw_abort,
  input  logic            bus_grant,
  output logic            bus_req_valid,
  output logic [XLEN-1:0] bus_req_addr,
  input  logic            bus_req_ready,
  input  logic            bus_rsp_valid,
  input  logic [XLEN-1:0] bus_rsp_data,
  input  logic            bus_rsp_err,
  output logic [15:0]     fault_count
);
  localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, RESP = 3'd3, DRAIN = 3'd4;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(XLEN / 8 - 1);
  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, data_q, data_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [15:0]     fault_q;
  logic            fault_inc, bad_addr, range_bad, timeout;
`ifdef PTW_PMA_CHECK_EN
  assign range_bad = ptw_req_addr < PT_BASE || ptw_req_addr > PT_LIMIT;
`else
  logic unused_range;
  assign unused_range = ^{PT_BASE, PT_LIMIT};
  assign range_bad = 1'b0;
`endif
  assign bad_addr       = |(ptw_req_addr & ALIGN_MASK) || range_bad;
  assign timeout        = timer_q == TW'(TIMEOUT_CYCLES - 1);
  assign ptw_req_ready  = state_q == IDLE && !ptw_abort;
  // Abort masks the request in the same cycle, so an aborted ISSUE never reaches the bus.
  assign bus_req_valid  = state_q == ISSUE && bus_grant && !ptw_abort;
  assign bus_req_addr   = addr_q;
  assign ptw_resp_valid = state_q == RESP && !ptw_abort;
  assign ptw_resp_data  = data_q;
  assign fault_count    = fault_q;
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    timer_d   = timer_q;
    fault_inc = 1'b0;
    case (state_q)
      IDLE: if (ptw_req_valid && ptw_req_ready) begin
        addr_d    = ptw_req_addr;
        data_d    = '0;
        fault_inc = bad_addr;
        state_d   = bad_addr ? RESP : ISSUE;
      end
      ISSUE: begin
        timer_d = '0;
        state_d = ptw_abort ? IDLE : (bus_req_valid && bus_req_ready) ? WAIT : ISSUE;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (ptw_abort)
          // A response or timeout in the abort cycle already closes the bus read.
          state_d = (bus_rsp_valid || timeout) ? IDLE : DRAIN;
        else if (bus_rsp_valid || timeout) begin
          data_d    = (bus_rsp_valid && !bus_rsp_err) ? bus_rsp_data : '0;
          fault_inc = !bus_rsp_valid || bus_rsp_err;
          state_d   = RESP;
        end
      end
      RESP:  state_d = IDLE;
      DRAIN: begin
        timer_d = timer_q + 1'b1;
        state_d = (bus_rsp_valid || timeout) ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      timer_q <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      timer_q <= timer_d;
      fault_q <= fault_q + {15'd0, fault_inc && fault_q != 16'hFFFF};
    end
  end
endmodule
